// File: rtl/exec_unit_pkg.sv
//==============================================================================
// Module : exec_unit_pkg
// Desc   : Op-code constants, FSM state encoding and decode helpers for exec_unit.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package exec_unit_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_PASSA = 4'd6;
    localparam logic [3:0] OP_SLL   = 4'd7;
    localparam logic [3:0] OP_SRL   = 4'd8;
    localparam logic [3:0] OP_SRA   = 4'd9;
    localparam logic [3:0] OP_SLLV  = 4'd10;
    localparam logic [3:0] OP_SRLV  = 4'd11;
    localparam logic [3:0] OP_SRAV  = 4'd12;
    localparam logic [3:0] OP_MULT  = 4'd13;
    localparam logic [3:0] OP_DIV   = 4'd14;
    localparam logic [3:0] OP_RSVD  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_var_shift(input logic [3:0] op);
        return (op == OP_SLLV) || (op == OP_SRLV) || (op == OP_SRAV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/exec_unit_muldiv_iter.sv
//==============================================================================
// Module : muldiv_iter
// Desc   : Signed multiply / divide, one bit per cycle over WIDTH cycles.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             running;
    logic [CW-1:0]    count;
    logic             div_mode;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] neg_prod;

    // Unsigned core on magnitudes; signs are reapplied to the final step.
    assign mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_comb begin
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        // Partial remainder stays below the divisor magnitude, so its MSB is 0.
        shifted = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        trial   = {1'b0, shifted} - {1'b0, operand};
        step_hi = sum[WIDTH:1];
        step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        if (div_mode) begin
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted;
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign neg_prod = ~{step_hi, step_lo} + 1'b1;
    assign done     = running && (count == LAST);

    always_comb begin
        hi = step_hi;
        lo = step_lo;
        if (div_mode) begin
            if (neg_r) hi = ~step_hi + 1'b1;
            if (neg_q) lo = ~step_lo + 1'b1;
        end else if (neg_q) begin
            hi = neg_prod[2*WIDTH-1:WIDTH];
            lo = neg_prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            running  <= 1'b0;
            count    <= '0;
            div_mode <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            operand  <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (start) begin
            running  <= 1'b1;
            count    <= '0;
            div_mode <= is_div;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r    <= a[WIDTH-1];
            operand  <= is_div ? mag_b : mag_a;
            acc_hi   <= '0;
            acc_lo   <= is_div ? mag_a : mag_b;
        end else if (running) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count + 1'b1;
            if (count == LAST) running <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/exec_unit.sv
//==============================================================================
// Module : exec_unit
// Desc   : Multi-cycle execution unit: single-cycle ALU/shifts, iterative mul/div.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             overflow,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             iter_req;
    logic [SHW-1:0]   shift_amt;
    logic [WIDTH-1:0] sum_ab;
    logic [WIDTH-1:0] dif_ab;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign accept    = start && (state == ST_IDLE);
    assign iter_req  = is_iter_op(op) && (src_b != '0);
    assign shift_amt = is_var_shift(op) ? src_a[SHW-1:0] : shamt;
    assign sum_ab    = src_a + src_b;
    assign dif_ab    = src_a - src_b;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_FIN);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum_ab;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum_ab[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif_ab;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (dif_ab[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:           alu_res = src_a & src_b;
            OP_OR:            alu_res = src_a | src_b;
            OP_XOR:           alu_res = src_a ^ src_b;
            OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_PASSA:         alu_res = src_a;
            OP_SLL, OP_SLLV:  alu_res = src_b << shift_amt;
            OP_SRL, OP_SRLV:  alu_res = src_b >> shift_amt;
            OP_SRA, OP_SRAV:  alu_res = $signed(src_b) >>> shift_amt;
            default:          alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = iter_req ? ST_ITER : ST_FIN;
            ST_ITER: if (md_done) state_next = ST_FIN;
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && iter_req),
        .is_div (op == OP_DIV),
        .a      (src_a),
        .b      (src_b),
        .done   (md_done),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            result      <= '0;
            hi          <= '0;
            lo          <= '0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (op <= OP_SRAV) begin
                    result      <= alu_res;
                    zero        <= (alu_res == '0);
                    overflow    <= alu_ovf;
                    div_by_zero <= 1'b0;
                    illegal_op  <= 1'b0;
                end else if (!iter_req) begin
                    // Reserved op, divide by zero, or multiply by zero finish immediately.
                    overflow    <= 1'b0;
                    zero        <= 1'b0;
                    div_by_zero <= (op == OP_DIV);
                    illegal_op  <= (op == OP_RSVD);
                    if (op == OP_MULT) begin
                        hi <= '0;
                        lo <= '0;
                    end
                end
            end else if ((state == ST_ITER) && md_done) begin
                hi          <= md_hi;
                lo          <= md_lo;
                overflow    <= 1'b0;
                zero        <= 1'b0;
                div_by_zero <= 1'b0;
                illegal_op  <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
//==============================================================================
// Module : tb_exec_unit
// Desc   : Directed self-checking bench for exec_unit (WIDTH=32).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_exec_unit;
    import exec_unit_pkg::*;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic [4:0]    shamt;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          overflow;
    logic          zero;
    logic          div_by_zero;
    logic          illegal_op;

    exec_unit #(.WIDTH(W), .SHW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .shamt       (shamt),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .hi          (hi),
        .lo          (lo),
        .overflow    (overflow),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Committed architectural state of the model, and the operation in flight.
    logic [W-1:0] m_res, m_hi, m_lo;
    logic         m_ovf, m_zero, m_dbz, m_ill;
    logic [W-1:0] p_res, p_hi, p_lo;
    logic         p_ovf, p_zero, p_dbz, p_ill;
    bit           pend = 1'b0;
    int           p_lat, p_start, p_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 25) $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        pend = 1'b0;
        m_res = '0; m_hi = '0; m_lo = '0;
        m_ovf = 1'b0; m_zero = 1'b0; m_dbz = 1'b0; m_ill = 1'b0;
    endtask

    task automatic model_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [4:0] s);
        longint la, lb, t;
        longint maxs, mins;
        logic [63:0] pv;
        logic [4:0]  amt;
        maxs = 64'sd2147483647;
        mins = -64'sd2147483648;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        amt = (o == OP_SLLV || o == OP_SRLV || o == OP_SRAV) ? a[4:0] : s;
        p_res = m_res; p_hi = m_hi; p_lo = m_lo;
        p_ovf = 1'b0; p_zero = 1'b0; p_dbz = 1'b0; p_ill = 1'b0;
        p_lat = 1;
        if (o <= OP_SRAV) begin
            case (o)
                OP_ADD:   begin t = la + lb; p_res = a + b; p_ovf = (t > maxs) || (t < mins); end
                OP_SUB:   begin t = la - lb; p_res = a - b; p_ovf = (t > maxs) || (t < mins); end
                OP_AND:   p_res = a & b;
                OP_OR:    p_res = a | b;
                OP_XOR:   p_res = a ^ b;
                OP_SLT:   p_res = (la < lb) ? 32'd1 : 32'd0;
                OP_PASSA: p_res = a;
                OP_SLL, OP_SLLV: p_res = b << amt;
                OP_SRL, OP_SRLV: p_res = b >> amt;
                default:  p_res = W'($signed(b) >>> amt);
            endcase
            p_zero = (p_res == 0);
        end else if (o == OP_MULT) begin
            pv = 64'(la * lb);
            p_hi = pv[63:32];
            p_lo = pv[31:0];
            if (b != 0) p_lat = W + 1;
        end else if (o == OP_DIV) begin
            if (b == 0) p_dbz = 1'b1;
            else begin
                t = la / lb; p_lo = t[31:0];
                t = la % lb; p_hi = t[31:0];
                p_lat = W + 1;
            end
        end else begin
            p_ill = 1'b1;
        end
    endtask

    // Per-cycle comparison against the model, sampled just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (chk_en) begin
                if (pend && cyc == p_done) begin
                    m_res = p_res; m_hi = p_hi; m_lo = p_lo;
                    m_ovf = p_ovf; m_zero = p_zero; m_dbz = p_dbz; m_ill = p_ill;
                end
                chk("busy", busy, pend && cyc > p_start && cyc <= p_done);
                chk("done", done, pend && cyc == p_done);
                chk("result", result, m_res);
                chk("hi", hi, m_hi);
                chk("lo", lo, m_lo);
                chk("overflow", overflow, m_ovf);
                chk("zero", zero, m_zero);
                chk("div_by_zero", div_by_zero, m_dbz);
                chk("illegal_op", illegal_op, m_ill);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] s);
        op = o; src_a = a; src_b = b; shamt = s; start = 1'b1;
        model_op(o, a, b, s);
        p_start = cyc;
        p_done  = cyc + p_lat;
        pend    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 4'($urandom); src_a = $urandom; src_b = $urandom; shamt = 5'($urandom);
    endtask

    task automatic wait_done(output int lat);
        int g = 0;
        while (done !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        total++;
        if (g >= 100) begin
            bad++;
            $display("FAIL done_timeout: got no done within 100 cycles, expected done");
        end
        lat = cyc - p_start;
    endtask

    // A request presented during the done cycle must be ignored.
    task automatic fin_poke();
        start = 1'b1; op = OP_ADD; src_a = 32'd100; src_b = 32'd200;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string nm, input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] s, input int exp_lat);
        int lat;
        issue(o, a, b, s);
        wait_done(lat);
        chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        fin_poke();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; shamt = '0;
        model_clear();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_result", result, 0);
        chk("reset_busy", busy, 0);
        @(negedge clk);

        run("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, 1);
        chk("add_ovf_result", result, 32'h8000_0000);
        chk("add_ovf_flag", overflow, 1);
        chk("add_ovf_zero", zero, 0);
        run("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 5'd0, 1);
        chk("sub_ovf_result", result, 32'h7FFF_FFFF);
        run("sub_zero", OP_SUB, 32'd5, 32'd5, 5'd0, 1);
        chk("sub_zero_flag", zero, 1);
        run("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 1);
        run("or", OP_OR, 32'hF000_0001, 32'h0000_0F00, 5'd0, 1);
        run("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0, 1);
        run("slt_t", OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 1);
        chk("slt_t_result", result, 1);
        run("slt_f", OP_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, 1);
        run("passa", OP_PASSA, 32'hDEAD_BEEF, 32'd0, 5'd0, 1);
        run("srav", OP_SRAV, 32'd4, 32'hF000_0000, 5'd0, 1);
        chk("srav_result", result, 32'hFF00_0000);
        run("sll", OP_SLL, 32'd0, 32'd1, 5'd31, 1);
        chk("sll_result", result, 32'h8000_0000);
        run("srl", OP_SRL, 32'd0, 32'hF000_0000, 5'd4, 1);
        run("sra", OP_SRA, 32'd0, 32'h8000_0010, 5'd4, 1);
        run("sllv", OP_SLLV, 32'h0000_0023, 32'd1, 5'd0, 1);
        run("srlv", OP_SRLV, 32'h0000_003F, 32'h8000_0000, 5'd0, 1);

        // MULT with ignored requests while busy and inputs scrambled.
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0);
        repeat (3) @(negedge clk);
        start = 1'b1; op = OP_ADD; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; op = OP_DIV; src_a = 32'd8; src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("mult_latency", 64'(lat), 33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        chk("mult_result_kept", result, 32'h0000_0001);
        fin_poke();

        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, 33);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        run("div_zero", OP_DIV, 32'd1234, 32'd0, 5'd0, 1);
        chk("div_zero_flag", div_by_zero, 1);
        chk("div_zero_lo_kept", lo, 32'hFFFF_FFFD);
        run("div_minneg", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 33);
        chk("div_minneg_lo", lo, 32'h8000_0000);
        chk("div_minneg_hi", hi, 32'h0);
        run("div_pos_neg", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd0, 33);
        run("mult_minneg", OP_MULT, 32'h8000_0000, 32'h8000_0000, 5'd0, 33);
        chk("mult_minneg_hi", hi, 32'h4000_0000);
        run("mult_mix", OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0, 33);
        run("illegal", OP_RSVD, 32'd1, 32'd2, 5'd3, 1);
        chk("illegal_flag", illegal_op, 1);

        // Reset aborts an in-flight MULT; no done may follow.
        issue(OP_MULT, 32'd12345, 32'd678, 5'd0);
        repeat (9) @(negedge clk);
        do_reset();
        repeat (40) @(negedge clk);
        run("add_after_rst", OP_ADD, 32'd2, 32'd3, 5'd0, 1);
        chk("add_after_rst_result", result, 32'd5);
        chk("add_after_rst_hi", hi, 0);
        chk("add_after_rst_lo", lo, 0);

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1; op = OP_ADD; src_a = 32'd1; src_b = 32'd1;
        model_clear();
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_start_result", result, 0);
        chk("rst_start_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; accepted only when busy=0.
REQ-006 SHALL have port op  input  4  operation code, sampled at acceptance.
REQ-007 SHALL have ports src_a, src_b  input  WIDTH  operands, sampled at acceptance.
REQ-008 SHALL have port shamt  input  SHW  immediate shift amount, sampled at acceptance.
REQ-009 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking valid outputs.
REQ-011 SHALL have ports result, hi, lo  output  WIDTH  registered results.
REQ-012 SHALL have ports overflow, zero, div_by_zero, illegal_op  output  1  registered flags.

Function
REQ-013 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 PASSA, 7 SLL, 8 SRL, 9 SRA, 10 SLLV, 11 SRLV, 12 SRAV, 13 MULT, 14 DIV, 15 reserved.
REQ-014 States SHALL be IDLE, ITER, FIN; IDLE->FIN on accepted single-cycle op; IDLE->ITER on accepted MULT/DIV with src_b!=0; ITER->FIN after WIDTH iterations; FIN->IDLE always.
REQ-015 Ops 0-12, op 15 and DIV with src_b=0 SHALL assert done exactly 1 cycle after acceptance (busy high for 1 cycle).
REQ-016 MULT and DIV (src_b!=0) SHALL assert done exactly WIDTH+1 cycles after acceptance.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow=1 on signed overflow, else 0; overflow=0 for all other ops.
REQ-018 SLT SHALL set result=1 if signed src_a<src_b, else 0.
REQ-019 SLL/SRL/SRA SHALL shift src_b by shamt; SLLV/SRLV/SRAV SHALL shift src_b by src_a[SHW-1:0]; SRA/SRAV sign-fill.
REQ-020 zero SHALL equal (result==0) for ops 0-12; zero=0 for MULT/DIV/15.
REQ-021 MULT SHALL compute signed {hi,lo}=src_a*src_b (2*WIDTH bits) by iterative shift-add; result unchanged.
REQ-022 DIV SHALL compute signed quotient into lo (truncated toward zero), remainder into hi (sign of dividend); most-negative/-1 SHALL give lo=most-negative, hi=0.
REQ-023 DIV with src_b=0 SHALL set div_by_zero=1 and leave hi, lo unchanged.
REQ-024 op 15 SHALL set illegal_op=1, leave result/hi/lo unchanged.
REQ-025 hi/lo SHALL change only on MULT/DIV completion; result only on ops 0-12 completion.
REQ-026 Flags overflow/zero/div_by_zero/illegal_op SHALL update at every done and hold until the next done.
REQ-027 start while busy=1 SHALL be ignored with no side effect; start in the FIN cycle SHALL be ignored.
REQ-028 Operands SHALL be latched at acceptance; input changes during busy SHALL not affect outcome.

Reset
REQ-029 reset SHALL force state IDLE, busy=0, done=0, result=hi=lo=0, all flags=0.
REQ-030 reset during ITER or FIN SHALL abort the operation; no done pulse SHALL follow.
REQ-031 reset SHALL take priority over a simultaneous start.

Structure
REQ-032 Op-code constants and state encoding SHALL live in shared package exec_unit_pkg.
REQ-033 Iterative multiply/divide SHALL be sub-module muldiv_iter (WIDTH-parameterised, start/done internal handshake).
REQ-034 Single-cycle ALU/shift datapath SHALL be combinational inside exec_unit, registered at FIN entry.

Verification
REQ-035 ADD 0x7FFFFFFF+1 (WIDTH=32) -> done after 1 cycle, result=0x80000000, overflow=1, zero=0.
REQ-036 SRAV src_a=4, src_b=0xF0000000 -> result=0xFF000000; SLL shamt=31, src_b=1 -> 0x80000000.
REQ-037 MULT -3 * 5 -> done exactly 33 cycles after acceptance, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-038 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV x/0 -> done after 1 cycle, div_by_zero=1, hi/lo unchanged.
REQ-039 start MULT, pulse reset at cycle 10, then start ADD 2+3 -> no MULT done, result=5, hi=lo=0.
REQ-040 start pulses during MULT busy -> ignored; single done pulse; op 15 -> illegal_op=1, result unchanged.
